// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: opcodes, state numbering,
// PC source selection and the instruction class list.
package multicycle_ctrl_pkg;

  localparam int STATE_W     = 3;
  localparam int PCSRC_W     = 2;
  localparam int WAIT_W      = 8;
  localparam int NUM_CLASSES = 7;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [PCSRC_W-1:0] PCSRC_P4  = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_BR  = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JAL = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd7
  } ctrlState_e;

  // Enum order doubles as the bit index of the one-hot class vector.
  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_JAL = 3'd5,
    CLS_ILL = 3'd6
  } instClass_e;

  function automatic instClass_e classFromOneHot(input logic [NUM_CLASSES-1:0] oneHot);
    instClass_e cls;
    cls = CLS_ILL;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (oneHot[i]) begin
        cls = instClass_e'(i[2:0]);
      end
    end
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/memory status in, step strobes,
// state and counters out. The controller sits on the master side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  import multicycle_ctrl_pkg::*;

  logic [6:0]         opCode;
  logic               zero;
  logic               imem_ready;
  logic               dmem_ready;
  logic               irWrite;
  logic               pcWrite;
  logic [PCSRC_W-1:0] pcSrc;
  logic               RegWrite;
  logic               ALUSrc;
  logic               MemRead;
  logic               MemWrite;
  logic               Mem2Reg;
  logic               link;
  logic [STATE_W-1:0] state;
  logic               fault;
  logic [CNT_W-1:0]   cycleCount;
  logic [CNT_W-1:0]   instret;

  modport master (
    input  opCode, zero, imem_ready, dmem_ready,
    output irWrite, pcWrite, pcSrc, RegWrite, ALUSrc, MemRead, MemWrite,
           Mem2Reg, link, state, fault, cycleCount, instret
  );

  modport slave (
    output opCode, zero, imem_ready, dmem_ready,
    input  irWrite, pcWrite, pcSrc, RegWrite, ALUSrc, MemRead, MemWrite,
           Mem2Reg, link, state, fault, cycleCount, instret
  );

endinterface

// File: rtl/multicycle_ctrl_op_classify.sv
// Combinational opcode classifier: exactly one bit of classOneHot is set,
// with anything unrecognised landing in the illegal class.
module multicycle_ctrl_op_classify
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0]             opCode,
  output logic [NUM_CLASSES-1:0] classOneHot
);

  always_comb begin
    classOneHot = '0;
    case (opCode)
      OP_R:    classOneHot[CLS_R]   = 1'b1;
      OP_I:    classOneHot[CLS_I]   = 1'b1;
      OP_LW:   classOneHot[CLS_LW]  = 1'b1;
      OP_SW:   classOneHot[CLS_SW]  = 1'b1;
      OP_BR:   classOneHot[CLS_BR]  = 1'b1;
      OP_JAL:  classOneHot[CLS_JAL] = 1'b1;
      default: classOneHot[CLS_ILL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready timeouts,
// a sticky fault state and free-running cycle / retired-instruction counters.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
)(
  input logic            clk,
  input logic            INT,
  multicycle_ctrl_if.master bus
);

  // The MEM_TIMEOUT-th consecutive not-ready cycle is the one that faults.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrlState_e              stateQ, nextState;
  instClass_e              classQ, decodedClass;
  logic [WAIT_W-1:0]       waitCnt, waitNext;
  logic [CNT_W-1:0]        cycleCount, instret;
  logic [NUM_CLASSES-1:0]  classOneHot;

  logic               irWriteC, pcWriteC, regWriteC, aluSrcC;
  logic               memReadC, memWriteC, mem2RegC, linkC;
  logic [PCSRC_W-1:0] pcSrcC;

  multicycle_ctrl_op_classify classifier (
    .opCode      (bus.opCode),
    .classOneHot (classOneHot)
  );

  assign decodedClass = classFromOneHot(classOneHot);

  always_ff @(posedge clk or posedge INT) begin
    if (INT) begin
      stateQ  <= FETCH;
      waitCnt <= '0;
      classQ  <= CLS_R;
    end else begin
      stateQ  <= nextState;
      waitCnt <= waitNext;
      if (stateQ == DECODE) begin
        classQ <= decodedClass;
      end
    end
  end

  // instret follows the ungated pcWrite; INT already holds the counters here.
  always_ff @(posedge clk or posedge INT) begin
    if (INT) begin
      cycleCount <= '0;
      instret    <= '0;
    end else begin
      cycleCount <= cycleCount + 1'b1;
      if (pcWriteC) begin
        instret <= instret + 1'b1;
      end
    end
  end

  always_comb begin
    nextState = stateQ;
    waitNext  = waitCnt;
    irWriteC  = 1'b0;
    pcWriteC  = 1'b0;
    pcSrcC    = PCSRC_P4;
    regWriteC = 1'b0;
    aluSrcC   = 1'b0;
    memReadC  = 1'b0;
    memWriteC = 1'b0;
    mem2RegC  = 1'b0;
    linkC     = 1'b0;

    case (stateQ)
      FETCH: begin
        irWriteC = bus.imem_ready;
        if (bus.imem_ready) begin
          nextState = DECODE;
          waitNext  = '0;
        end else if (waitCnt == WAIT_LAST) begin
          nextState = FAULT;
          waitNext  = '0;
        end else begin
          waitNext = waitCnt + 1'b1;
        end
      end

      DECODE: begin
        if (decodedClass == CLS_ILL) begin
          nextState = FAULT;
        end else if (decodedClass == CLS_JAL) begin
          nextState = WB;
        end else begin
          nextState = EXEC;
        end
      end

      EXEC: begin
        aluSrcC = (classQ == CLS_I) || (classQ == CLS_LW) || (classQ == CLS_SW);
        case (classQ)
          CLS_R, CLS_I:   nextState = WB;
          CLS_LW, CLS_SW: nextState = MEM;
          CLS_BR: begin
            pcWriteC  = 1'b1;
            pcSrcC    = bus.zero ? PCSRC_BR : PCSRC_P4;
            nextState = FETCH;
          end
          default:        nextState = FAULT;
        endcase
      end

      // The access strobe stays up through the cycle dmem_ready arrives.
      MEM: begin
        memReadC  = (classQ == CLS_LW);
        memWriteC = (classQ == CLS_SW);
        if ((classQ != CLS_LW) && (classQ != CLS_SW)) begin
          nextState = FAULT;
        end else if (bus.dmem_ready) begin
          waitNext = '0;
          if (classQ == CLS_LW) begin
            nextState = WB;
          end else begin
            pcWriteC  = 1'b1;
            nextState = FETCH;
          end
        end else if (waitCnt == WAIT_LAST) begin
          nextState = FAULT;
          waitNext  = '0;
        end else begin
          waitNext = waitCnt + 1'b1;
        end
      end

      WB: begin
        regWriteC = 1'b1;
        pcWriteC  = 1'b1;
        mem2RegC  = (classQ == CLS_LW);
        if (classQ == CLS_JAL) begin
          linkC  = 1'b1;
          pcSrcC = PCSRC_JAL;
        end
        nextState = FETCH;
      end

      FAULT: nextState = FAULT;

      default: nextState = FAULT;
    endcase
  end

  // Strobes are squashed combinationally so nothing leaks while INT is high.
  assign bus.irWrite    = irWriteC  & ~INT;
  assign bus.pcWrite    = pcWriteC  & ~INT;
  assign bus.pcSrc      = INT ? PCSRC_P4 : pcSrcC;
  assign bus.RegWrite   = regWriteC & ~INT;
  assign bus.ALUSrc     = aluSrcC   & ~INT;
  assign bus.MemRead    = memReadC  & ~INT;
  assign bus.MemWrite   = memWriteC & ~INT;
  assign bus.Mem2Reg    = mem2RegC  & ~INT;
  assign bus.link       = linkC     & ~INT;
  assign bus.state      = stateQ;
  assign bus.fault      = (stateQ == FAULT);
  assign bus.cycleCount = cycleCount;
  assign bus.instret    = instret;

endmodule
